timer_dev: RTL

- Memory-mapped programmable countdown timer on the CPU data bridge.
- Acts as the interrupt source for CP0: its `irq` output drives one bit of CP0's `hwirq[5:0]`.
- Software programs it with sw/lw. It raises a level interrupt (one-shot mode) or a one-cycle interrupt pulse (auto-reload mode).
- The CP0 exception handler acknowledges a one-shot interrupt by writing CTRL.

---
 rtl/timer_dev_pkg.sv | 24 ++
 rtl/timer_dev_if.sv | 12 +
 rtl/timer_dev_prescaler.sv | 28 ++
 rtl/timer_dev.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/timer_dev_pkg.sv
// Shared constants for the memory-mapped countdown timer: register offsets,
// CTRL bit positions, mode encodings and FSM state encodings.
package timer_dev_pkg;

   localparam logic [1:0] TIMER_CTRL   = 2'd0;
   localparam logic [1:0] TIMER_PRESET = 2'd1;
   localparam logic [1:0] TIMER_COUNT  = 2'd2;
   localparam logic [1:0] TIMER_PSC    = 2'd3;

   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_MODE_LSB = 1;
   localparam int CTRL_IM_BIT   = 3;

   localparam logic [1:0] TIMER_MODE_ONESHOT = 2'b00;
   localparam logic [1:0] TIMER_MODE_RELOAD  = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_CNT  = 2'd2,
      ST_INT  = 2'd3
   } timer_state_e;

endpackage

// File: rtl/timer_dev_if.sv
// Word-addressed register bus between the CPU data bridge and the timer.
interface timer_dev_if;

   logic [1:0]  addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (output addr, output we, output wdata, input rdata);
   modport slave  (input addr, input we, input wdata, output rdata);

endinterface

// File: rtl/timer_dev_prescaler.sv
// Tick generator that divides the count rate by PSC+1 while the timer counts.
// Only built when TIMER_PRESCALER_EN is defined.
`ifdef TIMER_PRESCALER_EN
module timer_prescaler (
   input  logic        clk,
   input  logic        rst,
   input  logic        clr,
   input  logic        run,
   input  logic [15:0] psc,
   output logic        tick
);

   logic [15:0] cnt;

   assign tick = run && (cnt == psc);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (run) begin
         cnt <= tick ? 16'd0 : cnt + 16'd1;
      end
   end

endmodule
`endif

// File: rtl/timer_dev.sv
// Programmable countdown timer acting as a CP0 interrupt source.
// Optional prescaler at offset 3 is enabled by defining TIMER_PRESCALER_EN.
module timer_dev
   import timer_dev_pkg::*;
#(
   parameter int COUNT_W = 32
) (
   input  logic       clk,
   input  logic       rst,
   timer_dev_if.slave bus,
   output logic       irq
);

   timer_state_e       state, state_nxt;
   logic               en, en_nxt;
   logic [1:0]         mode, mode_nxt;
   logic               im, im_nxt;
   logic [COUNT_W-1:0] preset, preset_nxt;
   logic [COUNT_W-1:0] count, count_nxt;
   logic               pending, pending_nxt;
   logic               ctrl_wr, preset_wr, tick;

   assign ctrl_wr   = bus.we && (bus.addr == TIMER_CTRL);
   assign preset_wr = bus.we && (bus.addr == TIMER_PRESET);

`ifdef TIMER_PRESCALER_EN
   logic [15:0] psc;
   logic        psc_wr;

   assign psc_wr = bus.we && (bus.addr == TIMER_PSC);

   timer_prescaler u_prescaler (
      .clk  (clk),
      .rst  (rst),
      .clr  (state == ST_LOAD),
      .run  (state == ST_CNT),
      .psc  (psc),
      .tick (tick)
   );

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         psc <= '0;
      end else if (psc_wr) begin
         psc <= bus.wdata[15:0];
      end
   end
`else
   assign tick = 1'b1;
`endif

   always_comb begin
      state_nxt   = state;
      en_nxt      = en;
      mode_nxt    = mode;
      im_nxt      = im;
      preset_nxt  = preset;
      count_nxt   = count;
      pending_nxt = pending;

      case (state)
         ST_IDLE: begin
            if (en) state_nxt = ST_LOAD;
         end
         ST_LOAD: begin
            count_nxt = preset;
            state_nxt = ST_CNT;
         end
         ST_CNT: begin
            if (!en) begin
               state_nxt = ST_IDLE;
            end else if (tick) begin
               // Zero check first so COUNT never wraps below zero
               if (count == '0) begin
                  state_nxt   = ST_INT;
                  pending_nxt = 1'b1;
               end else begin
                  count_nxt = count - COUNT_W'(1);
               end
            end
         end
         ST_INT: begin
            if (mode == TIMER_MODE_RELOAD) begin
               pending_nxt = 1'b0;
               state_nxt   = ST_LOAD;
            end else begin
               en_nxt    = 1'b0;
               state_nxt = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      // A CTRL write overrides the FSM's own EN clear and acknowledges pending
      if (ctrl_wr) begin
         en_nxt      = bus.wdata[CTRL_EN_BIT];
         mode_nxt    = bus.wdata[CTRL_MODE_LSB +: 2];
         im_nxt      = bus.wdata[CTRL_IM_BIT];
         pending_nxt = 1'b0;
      end
      if (preset_wr) preset_nxt = bus.wdata[COUNT_W-1:0];
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= ST_IDLE;
         en      <= 1'b0;
         mode    <= 2'b00;
         im      <= 1'b0;
         preset  <= '0;
         count   <= '0;
         pending <= 1'b0;
         irq     <= 1'b0;
      end else begin
         state   <= state_nxt;
         en      <= en_nxt;
         mode    <= mode_nxt;
         im      <= im_nxt;
         preset  <= preset_nxt;
         count   <= count_nxt;
         pending <= pending_nxt;
         irq     <= pending_nxt & im_nxt;
      end
   end

   always_comb begin
      bus.rdata = '0;
      case (bus.addr)
         TIMER_CTRL: begin
            bus.rdata[CTRL_EN_BIT]        = en;
            bus.rdata[CTRL_MODE_LSB +: 2] = mode;
            bus.rdata[CTRL_IM_BIT]        = im;
         end
         TIMER_PRESET: bus.rdata = 32'(preset);
         TIMER_COUNT:  bus.rdata = 32'(count);
         TIMER_PSC: begin
`ifdef TIMER_PRESCALER_EN
            bus.rdata = 32'(psc);
`else
            bus.rdata = '0;
`endif
         end
         default: bus.rdata = '0;
      endcase
   end

endmodule
